// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Owns the architectural PC, issues single-outstanding
//                instruction reads and presents fetched words through a
//                one-entry valid/ready output register; squashes stale fetches
//                on redirect.
//  Revision    : 1.0
// ============================================================================
module fetch_unit #(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [PC_WIDTH-1:0]    imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [INSTR_WIDTH-1:0] imem_resp_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr
);

    localparam logic [0:0]          c_ST_REQ  = 1'b0;
    localparam logic [0:0]          c_ST_WAIT = 1'b1;
    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);

    logic [0:0]             r_state;
    logic [0:0]             w_state_next;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_req_pc;
    logic                   r_drop;
    logic                   r_out_valid;
    logic [PC_WIDTH-1:0]    r_out_pc;
    logic [INSTR_WIDTH-1:0] r_out_instr;

    logic w_in_wait;
    logic w_req_fire;
    logic w_out_fire;
    logic w_resp_live;

    assign w_in_wait   = (r_state == c_ST_WAIT);
    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    // A response is kept only if it belongs to the current path and no
    // redirect is landing in the same cycle.
    assign w_resp_live = w_in_wait && imem_resp_valid && !r_drop && !redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_REQ:  if (w_req_fire)      w_state_next = c_ST_WAIT;
            c_ST_WAIT: if (imem_resp_valid) w_state_next = c_ST_REQ;
            default:                        w_state_next = c_ST_REQ;
        endcase
    end

    // Only request when the output slot is certain to be free by response time.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst && (r_state == c_ST_REQ)) begin
            imem_req_valid = !redirect_valid && (!r_out_valid || out_ready);
        end
    end

    assign imem_req_addr = r_pc;
    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_instr     = r_out_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_req_pc    <= '0;
            r_drop      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
        end else begin
            if (w_req_fire) begin
                r_req_pc <= r_pc;
            end
            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (w_resp_live) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= r_req_pc;
                r_out_instr <= imem_resp_data;
                r_pc        <= r_req_pc + c_PC_STEP;
            end
            // Exactly one stale response is ever owed, so repeated redirects keep drop set.
            if (w_in_wait && imem_resp_valid) begin
                r_drop <= 1'b0;
            end else if (w_in_wait && redirect_valid) begin
                r_drop <= 1'b1;
            end
            if (redirect_valid) begin
                r_pc        <= redirect_pc;
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed bench for fetch_unit with a transaction-level model,
//                a latency-programmable memory responder and literal checks.
//  Revision    : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam int            c_PW       = 64;
    localparam int            c_IW       = 32;
    localparam logic [63:0]   c_RESET_PC = 64'h0;

    logic              clk;
    logic              rst;
    logic              redirect_valid;
    logic [c_PW-1:0]   redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [c_PW-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [c_IW-1:0]   imem_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [c_PW-1:0]   out_pc;
    logic [c_IW-1:0]   out_instr;

    fetch_unit #(
        .PC_WIDTH    (c_PW),
        .INSTR_WIDTH (c_IW),
        .RESET_PC    (c_RESET_PC)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int mem_lat  = 1;
    int last_out_cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by 100000 time units, expected $finish");
        $fatal(1);
    end

    function automatic logic [c_IW-1:0] mem_word(input logic [c_PW-1:0] a);
        return a[31:0] ^ 32'hA5A5_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory: responds to each accepted read after mem_lat cycles.
    typedef struct {
        logic [c_PW-1:0] addr;
        int              due;
    } mem_t;
    mem_t mem_q[$];

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            @(negedge clk);
            if (imem_req_valid && imem_req_ready)
                mem_q.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
        end
    end

    // Transaction model: in-flight reads tagged live/stale, output slot as a flag.
    typedef struct {
        logic [c_PW-1:0] addr;
        bit              live;
    } flight_t;
    flight_t         m_flight[$];
    logic [c_PW-1:0] m_pc     = c_RESET_PC;
    bit              m_ofull  = 1'b0;
    logic [c_PW-1:0] m_opc    = '0;
    logic [c_IW-1:0] m_oinstr = '0;
    bit              m_exp_req;

    initial begin
        forever begin
            @(negedge clk);
            m_exp_req = !rst && (m_flight.size() == 0) && !redirect_valid && (!m_ofull || out_ready);
            chk("mdl_req_valid", 64'(imem_req_valid), 64'(m_exp_req));
            if (m_exp_req) chk("mdl_req_addr", imem_req_addr, m_pc);
            chk("mdl_out_valid", 64'(out_valid), 64'(m_ofull));
            if (m_ofull) begin
                chk("mdl_out_pc", out_pc, m_opc);
                chk("mdl_out_instr", 64'(out_instr), 64'(m_oinstr));
            end
            if (rst) begin
                m_pc    = c_RESET_PC;
                m_ofull = 1'b0;
                m_flight.delete();
            end else begin
                if (m_ofull && out_ready) m_ofull = 1'b0;
                if (imem_resp_valid && m_flight.size() != 0) begin
                    if (m_flight[0].live && !redirect_valid) begin
                        m_ofull  = 1'b1;
                        m_opc    = m_flight[0].addr;
                        m_oinstr = imem_resp_data;
                        m_pc     = m_flight[0].addr + 64'd4;
                    end
                    void'(m_flight.pop_front());
                end
                if (m_exp_req && imem_req_ready) m_flight.push_back('{addr: m_pc, live: 1'b1});
                if (redirect_valid) begin
                    m_pc    = redirect_pc;
                    m_ofull = 1'b0;
                    foreach (m_flight[i]) m_flight[i].live = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        redirect_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_out(input string nm, input logic [c_PW-1:0] epc, input logic [c_IW-1:0] ein);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got out_valid=0 for 40 cycles, expected out_valid=1", nm);
        end else begin
            chk({nm, "_pc"}, out_pc, epc);
            chk({nm, "_instr"}, 64'(out_instr), 64'(ein));
            last_out_cyc = cyc;
        end
    endtask

    task automatic wait_fire(input string nm, input logic [c_PW-1:0] ea, input bit strict);
        int n   = 0;
        bit got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready && (strict || imem_req_addr == ea)) got = 1'b1;
            n++;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no request fire in 40 cycles, expected fire at 0x%0h", nm, ea);
        end else begin
            chk({nm, "_addr"}, imem_req_addr, ea);
        end
    endtask

    initial begin
        int prev;
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;

        // Free-running stream: one instruction every 2 cycles.
        do_reset();
        wait_out("A0", 64'h0, 32'hA5A5_0013);
        prev = last_out_cyc;
        wait_out("A1", 64'h4, 32'hA5A5_0017);
        chk("A_gap1", 64'(last_out_cyc - prev), 64'd2);
        prev = last_out_cyc;
        wait_out("A2", 64'h8, 32'hA5A5_001B);
        chk("A_gap2", 64'(last_out_cyc - prev), 64'd2);
        wait_out("A3", 64'hC, 32'hA5A5_001F);

        // Decode stall holds the output and blocks new requests.
        do_reset();
        out_ready = 1'b0;
        wait_out("B_first", 64'h0, 32'hA5A5_0013);
        chk("B_noreq", 64'(imem_req_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("B_hold_valid", 64'(out_valid), 64'd1);
            chk("B_hold_pc", out_pc, 64'h0);
            chk("B_hold_noreq", 64'(imem_req_valid), 64'd0);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("B_resume_req", 64'(imem_req_valid), 64'd1);
        chk("B_resume_addr", imem_req_addr, 64'h4);
        wait_out("B_next", 64'h4, 32'hA5A5_0017);

        // Redirect while the 0x8 read is outstanding.
        mem_lat = 2;
        do_reset();
        wait_fire("C_req8", 64'h8, 1'b0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("C_flushed", 64'(out_valid), 64'd0);
        wait_fire("C_new", 64'h100, 1'b1);
        wait_out("C_out", 64'h100, 32'hA5A5_0113);

        // Redirect in the same cycle as the 0x4 response.
        do_reset();
        wait_fire("D_req4", 64'h4, 1'b0);
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("D_outv", 64'(out_valid), 64'd0);
        chk("D_req", 64'(imem_req_valid), 64'd1);
        chk("D_addr", imem_req_addr, 64'h200);
        wait_out("D_out", 64'h200, 32'hA5A5_0213);

        // Redirect flushes a full, stalled output register.
        mem_lat = 1;
        do_reset();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h10;
        @(negedge clk);
        chk("E_withdraw", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        wait_out("E_out", 64'h10, 32'hA5A5_0003);
        tick();
        @(negedge clk);
        chk("E_full", 64'(out_valid), 64'd1);
        chk("E_noreq", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        @(negedge clk);
        chk("E_redir_noreq", 64'(imem_req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("E_flushed", 64'(out_valid), 64'd0);
        chk("E_req", 64'(imem_req_valid), 64'd1);
        chk("E_addr", imem_req_addr, 64'h40);

        // PC wrap, then reset while a read is outstanding.
        tick();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_fire("F_top", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        tick();
        mem_lat = 3;
        wait_fire("F_wrap", 64'h0, 1'b1);
        tick();
        rst = 1'b1;
        imem_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("F_rst_req", 64'(imem_req_valid), 64'd1);
        chk("F_rst_addr", imem_req_addr, c_RESET_PC);
        tick();
        @(negedge clk);
        chk("F_late_ignored", 64'(out_valid), 64'd0);
        tick();
        imem_req_ready = 1'b1;
        mem_lat = 1;
        @(negedge clk);
        chk("F_late_ignored2", 64'(out_valid), 64'd0);
        wait_out("F_out", c_RESET_PC, 32'hA5A5_0013);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Consumes the next-PC decision and owns the architectural PC register.
- Issues instruction-memory read requests and presents fetched instructions to the IF/ID boundary through a valid/ready output.
- Handles control-flow redirects from the branch/jump resolution path. Any request or instruction fetched from the stale path is squashed.
- Single outstanding memory request; one-entry output register.

Parameters:
- PC_WIDTH, 64: width of PC and memory address.
- INSTR_WIDTH, 32: instruction word width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  one-cycle pulse; the fetch stream restarts at redirect_pc.
- redirect_pc  input  PC_WIDTH  redirect target (jump or taken-branch address).
- imem_req_valid  output  1  read request valid.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_req_addr  output  PC_WIDTH  read address; equals pc.
- imem_resp_valid  input  1  one-cycle response pulse; no backpressure.
- imem_resp_data  input  INSTR_WIDTH  instruction word.
- out_valid  output  1  out_pc/out_instr hold a valid fetched instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_pc  output  PC_WIDTH  PC of the presented instruction.
- out_instr  output  INSTR_WIDTH  presented instruction.

Behaviour:
- Reset:
  - Applies in the cycle rst=1. It takes priority over every other input, including redirect and response.
  - pc=RESET_PC; state=REQ; drop=0.
  - out_valid=0, out_pc=0, out_instr=0.
  - imem_req_valid=0 while rst=1.
- State REQ:
  - imem_req_valid = !redirect_valid && (!out_valid || out_ready). A request is issued only when the output register is guaranteed free by response time.
  - Handshake: request fires when imem_req_valid && imem_req_ready. The state then moves to WAIT and the issuing pc is saved as req_pc.
  - imem_req_addr and imem_req_valid stay stable until accepted. A redirect withdraws the request; this is allowed and is the only case where it happens.
- State WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid with drop=0: out_pc=req_pc, out_instr=imem_resp_data, out_valid=1, pc=req_pc+4, state moves to REQ.
  - On imem_resp_valid with drop=1: the response is discarded, drop clears, and the state moves to REQ (pc already holds the redirect target).
- Minimum latency: request accept at cycle N, response at N+k, out_valid at N+k+1. Next request can issue at N+k+1.
- Output register:
  - A handshake completes when out_valid && out_ready.
  - out_valid clears on the handshake unless a new response loads the register in the same cycle.
  - The design guarantees a response never arrives while the register is full and not draining.
- Redirect (redirect_valid=1, rst=0):
  - pc=redirect_pc; out_valid cleared (flush, no handshake with decode).
  - REQ, no accept this cycle: stay in REQ; the next request uses the new pc.
  - WAIT, no response this cycle: drop=1.
  - WAIT, response the same cycle: the response is discarded, state moves to REQ, drop=0.
  - A second redirect while drop=1 only updates pc; drop stays 1 (still one stale response).
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH. redirect_pc is used unmodified.
- A response in REQ state is a protocol violation; the design ignores it.

Test Plan:
- Reset then free-running: RESET_PC=0x0, imem_req_ready=1, 1-cycle response latency, out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, 0xC with matching out_instr, one instruction every 2 cycles.
- Decode stall: out_ready=0 after the first instruction -> out_valid held at 1, out_pc=0x0 stable, no further imem_req_valid. Raise out_ready -> the next request is issued at 0x4.
- Redirect during WAIT: request for 0x8 outstanding, redirect_valid with redirect_pc=0x100 -> the 0x8 response is dropped, the next request address is 0x100, and the next out_pc is 0x100.
- Redirect colliding with response: redirect to 0x200 in the same cycle as the 0x4 response -> 0x4 is never presented, out_valid=0, the next request address is 0x200.
- Redirect with a full output register: out_valid=1 at out_pc=0x10, out_ready=0, redirect to 0x40 -> out_valid is 0 the next cycle and the next request address is 0x40.
- Wrap and mid-operation reset: pc=0xFFFF_FFFF_FFFF_FFFC fetched -> the next address is 0x0. Asserting rst while in WAIT -> the next request address is RESET_PC and the late response is ignored.
